// File: rtl/dqsw_wrlvl_pkg.sv
// rtl/dqsw_wrlvl_pkg.sv - shared types and constants for the DQSW write-leveling controller
package dqsw_wrlvl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_LOAD_WAIT,
      ST_PULSE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_EVAL,
      ST_MOVE,
      ST_MOVE_WAIT,
      ST_DONE,
      ST_FAIL
   } wrlvl_state_t;

   localparam logic [1:0] DQS_PULSE = 2'b01;
   localparam logic [1:0] DQS_IDLE  = 2'b00;
   localparam logic [1:0] OE_ON     = 2'b11;
   localparam logic [1:0] OE_OFF    = 2'b00;

   function automatic logic is_busy(input wrlvl_state_t s);
      return !(s == ST_IDLE || s == ST_DONE || s == ST_FAIL);
   endfunction

endpackage

// File: rtl/wrlvl_majority.sv
// rtl/wrlvl_majority.sv - ones accumulator giving the majority vote over one tap's samples
module wrlvl_majority #(
   parameter int NUM_SAMPLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic result
);

   localparam int CNT_W = $clog2(NUM_SAMPLES) + 1;

   logic [CNT_W-1:0] ones;

   // Saturates at NUM_SAMPLES so a stray extra increment cannot wrap the vote.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         ones <= '0;
      end else if (inc && ones != CNT_W'(NUM_SAMPLES)) begin
         ones <= ones + 1'b1;
      end
   end

   // Strictly more than half: a tie votes 0.
   assign result = ones > CNT_W'(NUM_SAMPLES / 2);

endmodule

// File: rtl/dqsw_wrlvl_ctrl.sv
// rtl/dqsw_wrlvl_ctrl.sv - write-leveling controller for one DDR3 byte lane
// Steps the DQSW delay until the majority-voted DQ feedback goes 0->1.
module dqsw_wrlvl_ctrl
   import dqsw_wrlvl_pkg::*;
#(
   parameter int TAP_W         = 8,
   parameter int MAX_TAPS      = 128,
   parameter int SETTLE_CYCLES = 16,
   parameter int NUM_SAMPLES   = 8,
   parameter int MOVE_WAIT     = 4,
   parameter int LOAD_WAIT     = 4
) (
   input  logic             FAB_CLK,
   input  logic             RESET,
   input  logic             START,
   output logic             BUSY,
   output logic             DONE,
   output logic             FAIL,
   output logic [TAP_W-1:0] TAP_RESULT,
   output logic [1:0]       TX_DATA_0,
   output logic [1:0]       OE_DATA_0,
   input  logic [1:0]       RX_DATA_0,
   output logic             DELAY_LINE_MOVE_0,
   output logic             DELAY_LINE_DIRECTION_0,
   output logic             DELAY_LINE_LOAD_0,
   input  logic             DELAY_LINE_OUT_OF_RANGE_0,
   output logic             EYE_MONITOR_CLEAR_FLAGS_0
);

   localparam int SAMP_W   = $clog2(NUM_SAMPLES) + 1;
   localparam int WAIT_MAX = (SETTLE_CYCLES > MOVE_WAIT) ?
                             ((SETTLE_CYCLES > LOAD_WAIT) ? SETTLE_CYCLES : LOAD_WAIT) :
                             ((MOVE_WAIT > LOAD_WAIT) ? MOVE_WAIT : LOAD_WAIT);
   localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

   wrlvl_state_t     state, state_nxt;
   logic [TAP_W-1:0] tap, tap_nxt;
   logic [TAP_W-1:0] result_nxt;
   logic             seen_zero, seen_zero_nxt;
   logic [SAMP_W-1:0] samp_cnt, samp_cnt_nxt;
   logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             maj_clear, maj_inc, maj_result;
   logic             last_tap;
   logic             rx_fall_unused;

   assign rx_fall_unused = RX_DATA_0[1];
   assign last_tap       = (tap == TAP_W'(MAX_TAPS - 1));

   wrlvl_majority #(.NUM_SAMPLES(NUM_SAMPLES)) u_majority (
      .clk   (FAB_CLK),
      .rst   (RESET),
      .clear (maj_clear),
      .inc   (maj_inc),
      .result(maj_result)
   );

   always_comb begin
      state_nxt     = state;
      tap_nxt       = tap;
      result_nxt    = TAP_RESULT;
      seen_zero_nxt = seen_zero;
      samp_cnt_nxt  = samp_cnt;
      wait_cnt_nxt  = '0;
      maj_clear     = 1'b0;
      maj_inc       = 1'b0;
      case (state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (START) begin
               state_nxt     = ST_LOAD;
               tap_nxt       = '0;
               seen_zero_nxt = 1'b0;
               samp_cnt_nxt  = '0;
               maj_clear     = 1'b1;
            end
         end
         ST_LOAD: state_nxt = ST_LOAD_WAIT;
         ST_LOAD_WAIT: begin
            if (wait_cnt == WAIT_W'(LOAD_WAIT - 1)) state_nxt = ST_PULSE;
            else wait_cnt_nxt = wait_cnt + 1'b1;
         end
         ST_PULSE: state_nxt = ST_SETTLE;
         ST_SETTLE: begin
            if (wait_cnt == WAIT_W'(SETTLE_CYCLES - 1)) state_nxt = ST_SAMPLE;
            else wait_cnt_nxt = wait_cnt + 1'b1;
         end
         ST_SAMPLE: begin
            maj_inc      = RX_DATA_0[0];
            samp_cnt_nxt = samp_cnt + 1'b1;
            state_nxt    = (samp_cnt == SAMP_W'(NUM_SAMPLES - 1)) ? ST_EVAL : ST_PULSE;
         end
         ST_EVAL: begin
            samp_cnt_nxt = '0;
            maj_clear    = 1'b1;
            if (!maj_result) begin
               seen_zero_nxt = 1'b1;
               state_nxt     = ST_MOVE;
            end else if (seen_zero) begin
               result_nxt = tap;
               state_nxt  = ST_DONE;
            end else begin
               state_nxt = ST_MOVE;
            end
         end
         ST_MOVE: begin
            if (last_tap) begin
               state_nxt = ST_FAIL;
            end else begin
               tap_nxt   = tap + 1'b1;
               state_nxt = ST_MOVE_WAIT;
            end
         end
         ST_MOVE_WAIT: begin
            if (wait_cnt == WAIT_W'(MOVE_WAIT - 1)) state_nxt = ST_PULSE;
            else wait_cnt_nxt = wait_cnt + 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (is_busy(state) && DELAY_LINE_OUT_OF_RANGE_0) begin
         state_nxt = ST_FAIL;
      end
   end

   // Outputs are decoded from the next state so each is high exactly during its state's cycle.
   always_ff @(posedge FAB_CLK) begin
      if (RESET) begin
         state                     <= ST_IDLE;
         tap                       <= '0;
         seen_zero                 <= 1'b0;
         samp_cnt                  <= '0;
         wait_cnt                  <= '0;
         BUSY                      <= 1'b0;
         DONE                      <= 1'b0;
         FAIL                      <= 1'b0;
         TAP_RESULT                <= '0;
         TX_DATA_0                 <= DQS_IDLE;
         OE_DATA_0                 <= OE_OFF;
         DELAY_LINE_MOVE_0         <= 1'b0;
         DELAY_LINE_DIRECTION_0    <= 1'b0;
         DELAY_LINE_LOAD_0         <= 1'b0;
         EYE_MONITOR_CLEAR_FLAGS_0 <= 1'b0;
      end else begin
         state                     <= state_nxt;
         tap                       <= tap_nxt;
         seen_zero                 <= seen_zero_nxt;
         samp_cnt                  <= samp_cnt_nxt;
         wait_cnt                  <= wait_cnt_nxt;
         BUSY                      <= is_busy(state_nxt);
         DONE                      <= (state_nxt == ST_DONE);
         FAIL                      <= (state_nxt == ST_FAIL);
         TAP_RESULT                <= result_nxt;
         TX_DATA_0                 <= (state_nxt == ST_PULSE) ? DQS_PULSE : DQS_IDLE;
         OE_DATA_0                 <= (state_nxt == ST_PULSE) ? OE_ON : OE_OFF;
         DELAY_LINE_MOVE_0         <= (state_nxt == ST_MOVE) && (tap_nxt != TAP_W'(MAX_TAPS - 1));
         DELAY_LINE_DIRECTION_0    <= (state_nxt == ST_MOVE) && (tap_nxt != TAP_W'(MAX_TAPS - 1));
         DELAY_LINE_LOAD_0         <= (state_nxt == ST_LOAD);
         EYE_MONITOR_CLEAR_FLAGS_0 <= (state_nxt == ST_LOAD);
      end
   end

endmodule

// File: tb/tb_dqsw_wrlvl_ctrl.sv
// tb/tb_dqsw_wrlvl_ctrl.sv - self-checking bench for dqsw_wrlvl_ctrl with a tap-driven feedback model
module tb_dqsw_wrlvl_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       oor = 1'b0;
   logic       busy, done, fail, mv, dir, ld, clr;
   logic [7:0] tap_result;
   logic [1:0] tx, oe, rx;
   logic       fb;

   always #5 clk = ~clk;

   dqsw_wrlvl_ctrl dut (
      .FAB_CLK                  (clk),
      .RESET                    (rst),
      .START                    (start),
      .BUSY                     (busy),
      .DONE                     (done),
      .FAIL                     (fail),
      .TAP_RESULT               (tap_result),
      .TX_DATA_0                (tx),
      .OE_DATA_0                (oe),
      .RX_DATA_0                (rx),
      .DELAY_LINE_MOVE_0        (mv),
      .DELAY_LINE_DIRECTION_0   (dir),
      .DELAY_LINE_LOAD_0        (ld),
      .DELAY_LINE_OUT_OF_RANGE_0(oor),
      .EYE_MONITOR_CLEAR_FLAGS_0(clr)
   );

   typedef struct {
      int mode;
      int exp_done;
      int exp_fail;
      int exp_tap;
      int exp_moves;
      int exp_pulses;
   } vec_t;

   vec_t vecs[4];
   vec_t sb[$];
   vec_t exp;

   int mode = 1;
   int n_checks = 0;
   int n_fail = 0;

   // Lane model state, written only by the monitor below.
   int loads = 0, moves = 0, pulses = 0, tap_m = 0, pidx = 0, cyc = 0;
   int t_load = 0, t_pulse = 0, lat_lp = 0, lat_pm = 0;
   int oe_bad = 0, dir_bad = 0, clr_bad = 0;
   bit pend_p = 0, pend_m = 0;

   function automatic logic feedback(input int m, input int t, input int k);
      case (m)
         1: return t >= 20;
         2: return (t <= 5) || (t >= 31);
         5: begin
            if (t == 20) return (k % 2) == 1;
            else if (t >= 21) return k < 5;
            else return 1'b0;
         end
         default: return 1'b0;
      endcase
   endfunction

   assign fb = feedback(mode, tap_m, pidx - 1);
   assign rx = {1'b0, fb};

   always @(negedge clk) begin
      cyc++;
      if (ld) begin
         loads++; tap_m = 0; pidx = 0; t_load = cyc; pend_p = 1; pend_m = 1;
      end
      if (mv) begin
         moves++; tap_m++; pidx = 0;
         if (pend_m) begin lat_pm = cyc - t_pulse; pend_m = 0; end
      end
      if (tx == 2'b01) begin
         pulses++; pidx++;
         if (pend_p) begin lat_lp = cyc - t_load; t_pulse = cyc; pend_p = 0; end
      end
      if (!((tx == 2'b01 && oe == 2'b11) || (tx == 2'b00 && oe == 2'b00))) oe_bad++;
      if (mv && !dir) dir_bad++;
      if (clr != ld) clr_bad++;
   end

   task automatic check(input string name, input int act, input int expv);
      n_checks++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_end(output bit ok);
      ok = 0;
      for (int i = 0; i < 40000; i++) begin
         if (done || fail) begin ok = 1; return; end
         @(negedge clk);
      end
   endtask

   task automatic wait_tap(input int t, output bit ok);
      ok = 0;
      for (int i = 0; i < 40000; i++) begin
         if (tap_m == t) begin ok = 1; return; end
         @(negedge clk);
      end
   endtask

   task automatic wait_pulse(output bit ok);
      ok = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (tx == 2'b01) begin ok = 1; return; end
      end
   endtask

   initial begin
      bit ok;
      int l0, m0, p0;

      vecs[0] = '{1, 1, 0, 20, 20, 168};
      vecs[1] = '{2, 1, 0, 31, 31, 256};
      vecs[2] = '{3, 0, 1, 0, 127, 1024};
      vecs[3] = '{5, 1, 0, 21, 21, 176};

      repeat (3) @(negedge clk);
      check("reset_outputs", int'({busy, done, fail, tap_result, tx, oe, mv, dir, ld, clr}), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", int'(busy), 0);

      for (int i = 0; i < 4; i++) begin
         mode = vecs[i].mode;
         l0 = loads; m0 = moves; p0 = pulses;
         sb.push_back(vecs[i]);
         pulse_start();
         check("start_busy", int'(busy), 1);
         wait_end(ok);
         check("end_timeout", int'(ok), 1);
         exp = sb.pop_front();
         check("done", int'(done), exp.exp_done);
         check("fail", int'(fail), exp.exp_fail);
         if (exp.exp_done != 0) check("tap_result", int'(tap_result), exp.exp_tap);
         check("moves", moves - m0, exp.exp_moves);
         check("loads", loads - l0, 1);
         check("pulses", pulses - p0, exp.exp_pulses);
         check("end_busy", int'(busy), 0);
         if (i == 0) begin
            check("load_to_pulse", lat_lp, 5);
            check("pulse_to_move", lat_pm, 145);
         end
      end

      // Out-of-range while busy at tap 10.
      mode = 3;
      pulse_start();
      wait_tap(10, ok);
      check("oor_reach_tap10", int'(ok), 1);
      repeat (3) @(negedge clk);
      check("oor_busy_before", int'(busy), 1);
      oor = 1'b1;
      @(negedge clk);
      oor = 1'b0;
      check("oor_fail", int'(fail), 1);
      check("oor_busy", int'(busy), 0);
      check("oor_done", int'(done), 0);
      l0 = loads; m0 = moves; p0 = pulses;
      repeat (200) @(negedge clk);
      check("oor_quiet", (loads - l0) + (moves - m0) + (pulses - p0), 0);
      check("oor_fail_held", int'(fail), 1);

      // Reset during SETTLE at tap 7, restart, and a START while busy.
      mode = 1;
      pulse_start();
      wait_tap(7, ok);
      check("rst_reach_tap7", int'(ok), 1);
      wait_pulse(ok);
      check("rst_pulse_seen", int'(ok), 1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_outputs", int'({busy, done, fail, tap_result, tx, oe, mv, dir, ld, clr}), 0);
      rst = 1'b0;
      @(negedge clk);
      l0 = loads; m0 = moves;
      pulse_start();
      check("restart_busy", int'(busy), 1);
      repeat (5) @(negedge clk);
      pulse_start();
      check("busy_start_ignored", int'(busy), 1);
      wait_end(ok);
      check("restart_timeout", int'(ok), 1);
      check("restart_done", int'(done), 1);
      check("restart_tap", int'(tap_result), 20);
      check("restart_loads", loads - l0, 1);
      check("restart_moves", moves - m0, 20);

      check("oe_pattern", oe_bad, 0);
      check("move_direction", dir_bad, 0);
      check("clear_with_load", clr_bad, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dqsw_wrlvl_ctrl.md
Name: dqsw_wrlvl_ctrl

Overview:
- Fabric-side write-leveling controller for one DDR3 byte lane. Drives the DQSW training IOD lane.
- Emits DQS write pulses through TX_DATA/OE_DATA and samples the DQ feedback returned on RX_DATA.
- Steps the lane's dynamic delay line until it finds the 0->1 transition of the feedback, then reports the tap.
- Sits between the DDR training sequencer (START/DONE handshake) and the DQSW training IOD lane.

Parameters:
- TAP_W, 8, width of the tap counter and result.
- MAX_TAPS, 128, tap limit before FAIL (must be <= 2**TAP_W - 1).
- SETTLE_CYCLES, 16, FAB_CLK cycles from DQS pulse to first sample.
- NUM_SAMPLES, 8, samples per tap evaluation; power of two, >= 2.
- MOVE_WAIT, 4, idle cycles after each delay move.
- LOAD_WAIT, 4, idle cycles after delay load.

Ports:
- FAB_CLK  in  1  fabric clock, all logic rising-edge.
- RESET  in  1  synchronous reset, active-high.
- START  in  1  one-cycle request; ignored unless in IDLE, DONE or FAIL.
- BUSY  out  1  high in every state except IDLE/DONE/FAIL.
- DONE  out  1  level; edge found, held until next START or RESET.
- FAIL  out  1  level; no edge or out of range, held until next START or RESET.
- TAP_RESULT  out  TAP_W  tap at which the edge was found; valid while DONE.
- TX_DATA_0  out  2  DQS pattern to IOD.
- OE_DATA_0  out  2  output enable to IOD.
- RX_DATA_0  in  2  DQ feedback from IOD; bit 0 is the rising-edge sample.
- DELAY_LINE_MOVE_0  out  1  one-cycle move strobe.
- DELAY_LINE_DIRECTION_0  out  1  always 1 (increment) while moving.
- DELAY_LINE_LOAD_0  out  1  one-cycle load strobe; resets the delay to its base value.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  delay line saturated.
- EYE_MONITOR_CLEAR_FLAGS_0  out  1  pulsed together with DELAY_LINE_LOAD_0.

Behaviour:
- Reset values: all outputs 0. TAP_RESULT=0. State IDLE. Internal tap, sample and ones counters are 0. seen_zero=0.
- Outputs are registered. Strobes are exactly one cycle wide.
- IDLE/DONE/FAIL + START -> LOAD. Clear DONE, FAIL, tap=0, seen_zero=0.
- LOAD: DELAY_LINE_LOAD_0=1 and EYE_MONITOR_CLEAR_FLAGS_0=1 for one cycle -> LOAD_WAIT.
- LOAD_WAIT: count LOAD_WAIT cycles -> PULSE.
- PULSE: TX_DATA_0=2'b01, OE_DATA_0=2'b11 for one cycle; otherwise TX_DATA_0=2'b00, OE_DATA_0=2'b00 -> SETTLE.
- SETTLE: count SETTLE_CYCLES -> SAMPLE.
- SAMPLE: add RX_DATA_0[0] to the ones counter, then return to PULSE until NUM_SAMPLES samples are taken. One sample per DQS pulse. Then -> EVAL.
- EVAL, single cycle:
  - Majority result = ones > NUM_SAMPLES/2; a tie is 0.
  - Result 0: seen_zero=1 -> MOVE.
  - Result 1 and seen_zero=1: TAP_RESULT=tap -> DONE.
  - Result 1 and seen_zero=0: -> MOVE (skips the initial high region).
  - The ones counter is cleared on leaving EVAL.
- MOVE:
  - If tap==MAX_TAPS-1 -> FAIL; no move is issued.
  - Otherwise DELAY_LINE_MOVE_0=1 and DELAY_LINE_DIRECTION_0=1 for one cycle, tap+=1 -> MOVE_WAIT.
- MOVE_WAIT: count MOVE_WAIT cycles -> PULSE.
- DELAY_LINE_OUT_OF_RANGE_0=1 in any BUSY state -> FAIL next cycle. This has priority over the state's normal transition.
- START while BUSY: ignored.
- RESET mid-operation: immediate return to reset values. No further strobes; the IOD delay is left where it is.
- Counter widths: sample counter clog2(NUM_SAMPLES)+1; wait counter sized for max(SETTLE_CYCLES, MOVE_WAIT, LOAD_WAIT). Counters do not wrap.
- Latency of one tap evaluation = NUM_SAMPLES*(SETTLE_CYCLES+2)+1 cycles.

Decomposition:
- Package dqsw_wrlvl_pkg holds:
  - the state enum (IDLE, LOAD, LOAD_WAIT, PULSE, SETTLE, SAMPLE, EVAL, MOVE, MOVE_WAIT, DONE, FAIL);
  - the DQS pattern constants (2'b01, 2'b00) and OE_ON = 2'b11.
- One sub-module, wrlvl_majority: a ones accumulator with clear, increment and result ports, parameterised by NUM_SAMPLES.

Test Plan:
1. Feedback model returns 1 when tap >= 20, else 0; START -> DONE=1, TAP_RESULT=20, exactly 20 move strobes, one load strobe, FAIL=0.
2. Feedback is 1 for taps 0..5, 0 for 6..30, 1 from tap 31; START -> initial high region skipped, DONE with TAP_RESULT=31.
3. Feedback is always 0; START -> FAIL=1 after 127 moves, DONE=0, no move strobe at tap 127.
4. Assert DELAY_LINE_OUT_OF_RANGE_0 while at tap 10 -> FAIL the next cycle, BUSY=0, no further strobes.
5. Noisy feedback at tap 20 with exactly 4 of 8 samples high -> treated as 0 (tie), edge reported at the first tap with at least 5 of 8 high.
6. RESET asserted during SETTLE at tap 7 -> all outputs 0 the next cycle. A new START then restarts from LOAD, and a second START issued while BUSY is ignored.
